// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - TCDM request front-end for one SRAM bank with atomic read-modify-write
// and an in-order response FIFO.
package tcdm_bank_responder_pkg;
  localparam int unsigned IdWidth = 6;
  typedef logic [3:0] strb_t;
  typedef logic [3:0] amo_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    amo_t               amo;
    logic [31:0]        data;
  } tcdm_payload_t;
  localparam amo_t AmoSwap = 4'd1;
  localparam amo_t AmoAdd  = 4'd2;
  localparam amo_t AmoAnd  = 4'd3;
  localparam amo_t AmoOr   = 4'd4;
  localparam amo_t AmoXor  = 4'd5;
  localparam amo_t AmoMax  = 4'd6;
  localparam amo_t AmoMaxu = 4'd7;
  localparam amo_t AmoMin  = 4'd8;
  localparam amo_t AmoMinu = 4'd9;
endpackage

module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 10,
  parameter int unsigned RespDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [AddrMemWidth-1:0] in_address_i,
  input  logic                    in_write_i,
  input  strb_t                   in_be_i,
  input  tcdm_payload_t           in_payload_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output tcdm_payload_t           out_payload_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_addr_o,
  output strb_t                   mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i
);

  localparam int unsigned PtrW = $clog2(RespDepth);
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAmoRmw = 1'b1;

  if (RespDepth < 2) begin : g_depth_check
    $error("RespDepth must be at least 2");
  end

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        data;
  } resp_t;

  logic [0:0]              state_q, state_d;
  logic                    inflight_q, inflight_d;
  logic [IdWidth-1:0]      req_id_q;
  logic                    req_write_q;
  logic [AddrMemWidth-1:0] amo_addr_q;
  amo_t                    amo_op_q;
  logic [31:0]             amo_operand_q;
  resp_t                   fifo_q [RespDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;

  logic        is_amo, accept, push, pop;
  logic [CntW:0] occupancy;
  logic [31:0] amo_result;
  resp_t       push_data;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_amo     = (in_payload_i.amo >= AmoSwap) && (in_payload_i.amo <= AmoMinu);
  assign pop        = out_valid_o && out_ready_i;
  // Count a response that is still one cycle away from the FIFO as already occupying a slot.
  assign occupancy  = {1'b0, count_q} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
  assign in_ready_o = rst_ni && (state_q == StIdle) && (occupancy < (CntW+1)'(RespDepth));
  assign accept     = in_valid_i && in_ready_o;

  assign state_d    = (accept && is_amo) ? StAmoRmw : StIdle;
  assign inflight_d = accept && !is_amo;
  assign push       = inflight_q || (state_q == StAmoRmw);

  always_comb begin
    amo_result = mem_rdata_i;
    unique case (amo_op_q)
      AmoSwap: amo_result = amo_operand_q;
      AmoAdd:  amo_result = mem_rdata_i + amo_operand_q;
      AmoAnd:  amo_result = mem_rdata_i & amo_operand_q;
      AmoOr:   amo_result = mem_rdata_i | amo_operand_q;
      AmoXor:  amo_result = mem_rdata_i ^ amo_operand_q;
      AmoMax:  amo_result = ($signed(mem_rdata_i) > $signed(amo_operand_q)) ? mem_rdata_i : amo_operand_q;
      AmoMaxu: amo_result = (mem_rdata_i > amo_operand_q) ? mem_rdata_i : amo_operand_q;
      AmoMin:  amo_result = ($signed(mem_rdata_i) < $signed(amo_operand_q)) ? mem_rdata_i : amo_operand_q;
      AmoMinu: amo_result = (mem_rdata_i < amo_operand_q) ? mem_rdata_i : amo_operand_q;
      default: amo_result = mem_rdata_i;
    endcase
  end

  always_comb begin
    mem_req_o   = accept;
    mem_we_o    = accept && in_write_i && !is_amo;
    mem_addr_o  = in_address_i;
    mem_be_o    = is_amo ? 4'hF : in_be_i;
    mem_wdata_o = in_payload_i.data;
    if (state_q == StAmoRmw) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = amo_addr_q;
      mem_be_o    = 4'hF;
      mem_wdata_o = amo_result;
    end
  end

  always_comb begin
    push_data.id   = req_id_q;
    push_data.data = (req_write_q && (state_q == StIdle)) ? 32'h0 : mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_id_q      <= in_payload_i.id;
      req_write_q   <= in_write_i;
      amo_addr_q    <= in_address_i;
      amo_op_q      <= in_payload_i.amo;
      amo_operand_q <= in_payload_i.data;
    end
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    out_valid_o        = (count_q != '0);
    out_payload_o.id   = fifo_q[rd_ptr_q].id;
    out_payload_o.amo  = '0;
    out_payload_o.data = fifo_q[rd_ptr_q].data;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && (count_q == CntW'(RespDepth))))
    else $error("response pushed into full FIFO");

endmodule
